// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants and input-state type for the JPEG block sequencer
package jpeg_pkg;

  localparam int BLK_N          = 8;
  localparam int BLK_SZ         = BLK_N * BLK_N;
  localparam int IDX_W          = 6;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SZ - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } in_state_t;

endpackage

// File: rtl/jpeg_blk_buf.sv
// rtl/jpeg_blk_buf.sv - 64-entry sample register with indexed write and flattened parallel read
module jpeg_blk_buf
  import jpeg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [BLK_SZ*DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [BLK_SZ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_SZ; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < BLK_SZ; g++) begin : g_flat
    assign q[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// rtl/jpeg_block_sequencer.sv - serial-in/serial-out wrapper holding 8x8 blocks on a combinational core
module jpeg_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic [BLK_SZ*DATA_W-1:0] core_h,
  input  logic [BLK_SZ*DATA_W-1:0] core_i,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic [15:0]              blocks_done
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  in_state_t         state, state_nxt;
  logic              started;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [7:0]        settle_cnt;
  logic              out_full;
  logic [DATA_W-1:0] out_buf [BLK_SZ];
  logic              accept;
  logic              pop;
  logic              last_pop;
  logic              cap_ok;
  logic              capture;

  assign accept   = s_valid & s_ready;
  assign pop      = out_full & m_ready;
  assign last_pop = pop & (rd_idx == LAST_IDX);
  // The final beat of the old result frees out_buf in the same cycle it is reloaded.
  assign cap_ok   = !out_full | last_pop;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    capture   = 1'b0;
    unique case (state)
      FILL: begin
        s_ready = started;
        if (s_valid && started && wr_idx == LAST_IDX) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          if (cap_ok) begin
            capture   = 1'b1;
            state_nxt = FILL;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (cap_ok) begin
          capture   = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      started    <= 1'b0;
      wr_idx     <= '0;
      settle_cnt <= '0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      if (capture) wr_idx <= '0;
      else if (accept && wr_idx != LAST_IDX) wr_idx <= wr_idx + 1'b1;
      if (state == SETTLE) settle_cnt <= settle_cnt + 8'd1;
      else settle_cnt <= '0;
    end
  end

  jpeg_blk_buf #(.DATA_W(DATA_W)) u_in_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .q       (core_h)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full    <= 1'b0;
      rd_idx      <= '0;
      blocks_done <= '0;
      for (int i = 0; i < BLK_SZ; i++) out_buf[i] <= '0;
    end else if (capture) begin
      out_full    <= 1'b1;
      rd_idx      <= '0;
      blocks_done <= blocks_done + 16'd1;
      for (int i = 0; i < BLK_SZ; i++) out_buf[i] <= core_i[i*DATA_W +: DATA_W];
    end else if (pop) begin
      rd_idx <= last_pop ? '0 : rd_idx + 1'b1;
      if (last_pop) out_full <= 1'b0;
    end
  end

  assign m_valid = out_full;
  assign m_data  = out_buf[rd_idx];
  assign m_last  = out_full && (rd_idx == LAST_IDX);
  assign busy    = (wr_idx != '0) || (state != FILL) || out_full;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// tb/tb_jpeg_block_sequencer.sv - randomized self-checking bench with a block-level reference model
module tb_jpeg_block_sequencer;

  localparam int DW     = 16;
  localparam int NB     = 64;
  localparam int SETTLE = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [DW-1:0]  s_data = '0;
  logic [NB*DW-1:0] core_h;
  logic [NB*DW-1:0] core_i;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  m_data;
  logic           m_last;
  logic           busy;
  logic [15:0]    blocks_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_pct = 100;
  int ready_pct = 100;
  int core_mode = 0;

  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  logic [NB*DW-1:0] cur_blk = '0;
  int   cur_cnt = 0;
  int   out_beat = 0;
  int   bd_exp = 0;
  int   last_acc_cyc = 0;
  int   mv_rise_cyc = 0;
  logic prev_stall = 1'b0;
  logic prev_mv = 1'b0;
  logic [DW-1:0] prev_data = '0;

  jpeg_block_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .core_h      (core_h),
    .core_i      (core_i),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .blocks_done (blocks_done)
  );

  // Mode 0: +1 per sample. Mode 1: stand-in "real" core mixing transposed samples.
  function automatic logic [NB*DW-1:0] core_fn(input logic [NB*DW-1:0] h, input int mode);
    logic [NB*DW-1:0] o;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (mode == 0) o[(r*8+c)*DW +: DW] = h[(r*8+c)*DW +: DW] + 16'd1;
        else o[(r*8+c)*DW +: DW] = h[(c*8+r)*DW +: DW] ^ 16'((r*8+c)*37);
      end
    end
    return o;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb core_i = core_fn(core_h, core_mode);

  initial begin : bfm
    logic [NB*DW-1:0] outv;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (s_valid && s_ready) begin
          cur_blk[cur_cnt*DW +: DW] = s_data;
          void'(in_q.pop_front());
          acc_q.push_back(cyc);
          last_acc_cyc = cyc;
          cur_cnt++;
          if (cur_cnt == NB) begin
            outv = core_fn(cur_blk, core_mode);
            for (int k = 0; k < NB; k++) exp_q.push_back(outv[k*DW +: DW]);
            cur_cnt = 0;
            bd_exp++;
          end
        end
        if (prev_stall) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold got m_valid=%0b m_data=%0h expected m_valid=1 m_data=%0h", m_valid, m_data, prev_data);
          end
        end
        if (m_valid && !prev_mv) mv_rise_cyc = cyc;
        if (m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got m_data=%0h expected no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              errors++;
              $display("FAIL m_data beat %0d got %0h expected %0h", out_beat, m_data, e);
            end
            checks++;
            if (m_last !== (out_beat == NB-1)) begin
              errors++;
              $display("FAIL m_last beat %0d got %0b expected %0b", out_beat, m_last, out_beat == NB-1);
            end
          end
          out_beat = (out_beat + 1) % NB;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_mv    = m_valid;
      end else begin
        prev_stall = 1'b0;
        prev_mv    = 1'b0;
      end
      @(posedge clk);
      #1;
      s_valid = (in_q.size() > 0) && ($urandom_range(99) < valid_pct);
      s_data  = (in_q.size() > 0) ? in_q[0] : DW'($urandom);
      m_ready = ($urandom_range(99) < ready_pct);
    end
  end

  function automatic void flush_model();
    in_q.delete();
    exp_q.delete();
    cur_cnt    = 0;
    out_beat   = 0;
    bd_exp     = 0;
    prev_stall = 1'b0;
    prev_mv    = 1'b0;
    s_valid    = 1'b0;
  endfunction

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (!(in_q.size() == 0 && exp_q.size() == 0 && cur_cnt == 0 && !m_valid) && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s_timeout got pending_in=%0d pending_out=%0d expected 0 within %0d cycles", name, in_q.size(), exp_q.size(), max_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got s_ready=%0b m_valid=%0b m_last=%0b busy=%0b expected 0", s_ready, m_valid, m_last, busy);
    end
    checks++;
    if (m_data !== '0 || blocks_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_values got m_data=%0h blocks_done=%0h expected 0", m_data, blocks_done);
    end
    checks++;
    if (core_h !== '0) begin
      errors++;
      $display("FAIL reset_core_h got nonzero expected 0");
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL s_ready_before_edge got %0b expected 0", s_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL s_ready_after_edge got %0b expected 1", s_ready);
    end
  endtask

  task automatic test_single();
    valid_pct = 100;
    ready_pct = 100;
    for (int k = 0; k < NB; k++) in_q.push_back(DW'(k*256));
    wait_idle("single", 2000);
    checks++;
    if (mv_rise_cyc - last_acc_cyc != SETTLE + 1) begin
      errors++;
      $display("FAIL single_latency got %0d expected %0d", mv_rise_cyc - last_acc_cyc, SETTLE + 1);
    end
    checks++;
    if (blocks_done !== 16'd1) begin
      errors++;
      $display("FAIL single_blocks_done got %0d expected 1", blocks_done);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a0;
    int n = 0;
    int gaps = 0;
    valid_pct = 100;
    ready_pct = 0;
    a0 = DW'($urandom);
    in_q.push_back(a0);
    for (int k = 1; k < 2*NB; k++) in_q.push_back(DW'($urandom));
    while (in_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_flags got s_ready=%0b busy=%0b expected s_ready=0 busy=1", s_ready, busy);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== a0 + 16'd1) begin
      errors++;
      $display("FAIL hold_data got m_valid=%0b m_data=%0h expected m_valid=1 m_data=%0h", m_valid, m_data, a0 + 16'd1);
    end
    checks++;
    if (blocks_done !== 16'(bd_exp - 1)) begin
      errors++;
      $display("FAIL hold_blocks_done got %0d expected %0d", blocks_done, bd_exp - 1);
    end
    ready_pct = 100;
    n = 0;
    for (int i = 0; i < 300 && n < 2*NB; i++) begin
      @(negedge clk);
      #1;
      if (m_valid && m_ready) n++;
      else if (n > 0) gaps++;
    end
    checks++;
    if (n != 2*NB || gaps != 0) begin
      errors++;
      $display("FAIL release_drain got beats=%0d gaps=%0d expected beats=%0d gaps=0", n, gaps, 2*NB);
    end
    wait_idle("backpressure", 500);
    checks++;
    if (blocks_done !== 16'(bd_exp)) begin
      errors++;
      $display("FAIL backpressure_blocks_done got %0d expected %0d", blocks_done, bd_exp);
    end
  endtask

  task automatic test_streaming();
    int st;
    int w0 = 0;
    int w1 = 0;
    int base;
    base = bd_exp;
    valid_pct = 100;
    ready_pct = 100;
    acc_q.delete();
    for (int k = 0; k < 4*NB; k++) in_q.push_back(DW'($urandom));
    wait_idle("streaming", 2000);
    st = (acc_q.size() > 0) ? acc_q[0] : 0;
    foreach (acc_q[i]) begin
      if (acc_q[i] >= st && acc_q[i] < st + NB + SETTLE) w0++;
      else if (acc_q[i] >= st + NB + SETTLE && acc_q[i] < st + 2*(NB + SETTLE)) w1++;
    end
    checks++;
    if (w0 != NB || w1 != NB) begin
      errors++;
      $display("FAIL stream_duty got w0=%0d w1=%0d expected %0d each", w0, w1, NB);
    end
    checks++;
    if (blocks_done !== 16'(base + 4)) begin
      errors++;
      $display("FAIL stream_blocks_done got %0d expected %0d", blocks_done, base + 4);
    end
  endtask

  task automatic test_random();
    int base;
    base = bd_exp;
    valid_pct = 50;
    ready_pct = 50;
    for (int k = 0; k < 10*NB; k++) in_q.push_back(DW'($urandom));
    wait_idle("random", 20000);
    checks++;
    if (blocks_done !== 16'(base + 10)) begin
      errors++;
      $display("FAIL random_blocks_done got %0d expected %0d", blocks_done, base + 10);
    end
    valid_pct = 100;
    ready_pct = 100;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    valid_pct = 100;
    ready_pct = 100;
    for (int k = 0; k < NB; k++) in_q.push_back(DW'($urandom));
    while (cur_cnt < 30 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    flush_model();
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, busy} !== 4'b0 || m_data !== '0 || blocks_done !== 16'd0 || core_h !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill got s_ready=%0b m_valid=%0b busy=%0b m_data=%0h blocks_done=%0d core_h_zero=%0b expected all zero",
               s_ready, m_valid, busy, m_data, blocks_done, core_h == '0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) in_q.push_back(DW'($urandom));
    wait_idle("fresh_after_fill_reset", 2000);
    checks++;
    if (blocks_done !== 16'd1) begin
      errors++;
      $display("FAIL fresh_blocks_done got %0d expected 1", blocks_done);
    end

    ready_pct = 0;
    for (int k = 0; k < NB; k++) in_q.push_back(DW'($urandom));
    n = 0;
    while (!m_valid && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    ready_pct = 100;
    n = 0;
    while (out_beat < 20 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    flush_model();
    #1;
    checks++;
    if ({s_ready, m_valid, m_last, busy} !== 4'b0 || m_data !== '0 || blocks_done !== 16'd0 || core_h !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain got s_ready=%0b m_valid=%0b busy=%0b m_data=%0h blocks_done=%0d core_h_zero=%0b expected all zero",
               s_ready, m_valid, busy, m_data, blocks_done, core_h == '0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) in_q.push_back(DW'($urandom));
    wait_idle("fresh_after_drain_reset", 2000);
    checks++;
    if (blocks_done !== 16'd1) begin
      errors++;
      $display("FAIL fresh_drain_blocks_done got %0d expected 1", blocks_done);
    end
  endtask

  task automatic test_core();
    int base;
    base = bd_exp;
    core_mode = 1;
    for (int k = 0; k < NB; k++) begin
      if (k == 0) in_q.push_back(16'h1C00);
      else if (k == 1) in_q.push_back(16'h2000);
      else if (k == NB-1) in_q.push_back(16'h2100);
      else in_q.push_back(DW'(16'h1C00 + k*16));
    end
    wait_idle("core", 2000);
    checks++;
    if (blocks_done !== 16'(base + 1)) begin
      errors++;
      $display("FAIL core_blocks_done got %0d expected %0d", blocks_done, base + 1);
    end
    core_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    test_core();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
